// File: rtl/colisao_inimigos_if.sv
// Bus between the bullet/game top level and the enemy collision stage.
// The game side (master) drives the bullet, grid and control inputs. The
// collision stage (slave) returns the alive bitmap, score and hit pulse.
// acerto is a one-cycle pulse; indiceAcerto is valid while it is high.
interface colisao_inimigos_if #(
    parameter int NUM = 32
);
    logic             reiniciarJogo;
    logic             pausa;
    logic             bolaAtiva;
    logic [9:0]       bolaX;
    logic [9:0]       bolaY;
    logic [9:0]       raio;
    logic [9:0]       gradeX;
    logic [9:0]       gradeY;
    logic [NUM-1:0]   vivos;
    logic             acerto;
    logic [5:0]       indiceAcerto;
    logic [15:0]      pontos;
    logic             todosMortos;
    logic             ocupado;

    modport master (
        output reiniciarJogo, pausa, bolaAtiva, bolaX, bolaY, raio, gradeX, gradeY,
        input  vivos, acerto, indiceAcerto, pontos, todosMortos, ocupado
    );

    modport slave (
        input  reiniciarJogo, pausa, bolaAtiva, bolaX, bolaY, raio, gradeX, gradeY,
        output vivos, acerto, indiceAcerto, pontos, todosMortos, ocupado
    );
endinterface

// File: rtl/colisao_inimigos.sv
// Enemy collision stage: scans the enemy grid one cell per cycle against the
// bullet bounding box, kills the lowest-index live overlapping enemy, keeps
// the alive bitmap and the score. estado_o exposes the FSM state for debug.
module colisao_inimigos #(
    parameter int LINHAS            = 4,
    parameter int COLUNAS           = 8,
    parameter int LARG_INIMIGO      = 24,
    parameter int ALT_INIMIGO       = 16,
    parameter int PASSO_X           = 40,
    parameter int PASSO_Y           = 30,
    parameter int PONTOS_POR_ACERTO = 10
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    colisao_inimigos_if.slave   bus,
    output logic [1:0]          estado_o
);
    localparam int N  = LINHAS * COLUNAS;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (COLUNAS > 1) ? $clog2(COLUNAS) : 1;
    localparam int LW = (LINHAS > 1) ? $clog2(LINHAS) : 1;

    localparam logic [1:0] OCIOSO  = 2'd0;
    localparam logic [1:0] AMOSTRA = 2'd1;
    localparam logic [1:0] VARRE   = 2'd2;
    localparam logic [1:0] ACERTO  = 2'd3;

    logic [1:0]    st_q, st_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] col_q, col_d;
    logic [LW-1:0] lin_q, lin_d;
    logic [9:0]    sx_q, sx_d, sy_q, sy_d, sr_q, sr_d, gx_q, gx_d, gy_q, gy_d;
    logic [9:0]    last_x_q, last_x_d, last_y_q, last_y_d;
    logic          prev_ativa_q, prev_ativa_d;
    logic [N-1:0]  vivos_q, vivos_d;
    logic [15:0]   pontos_q, pontos_d;
    logic [5:0]    indice_q, indice_d;
    logic          todos_q, todos_d;

    logic          disparo;
    logic [10:0]   bx_lo, bx_hi, by_lo, by_hi;
    logic [10:0]   cx_lo, cx_hi, cy_lo, cy_hi;
    logic          acerta_celula;
    logic          ultima;
    logic [16:0]   soma;

    // Trigger on a new bullet position or a fresh bullet launch
    assign disparo = bus.bolaAtiva && !bus.pausa &&
                     (({bus.bolaX, bus.bolaY} != {last_x_q, last_y_q}) || !prev_ativa_q);

    // Bullet box and current cell box in 11 bits; bullet low edges saturate at 0
    always_comb begin
        bx_lo = (sx_q >= sr_q) ? {1'b0, sx_q - sr_q} : 11'd0;
        by_lo = (sy_q >= sr_q) ? {1'b0, sy_q - sr_q} : 11'd0;
        bx_hi = {1'b0, sx_q} + {1'b0, sr_q};
        by_hi = {1'b0, sy_q} + {1'b0, sr_q};
        cx_lo = {1'b0, gx_q} + 11'(col_q * PASSO_X);
        cy_lo = {1'b0, gy_q} + 11'(lin_q * PASSO_Y);
        cx_hi = cx_lo + 11'(LARG_INIMIGO - 1);
        cy_hi = cy_lo + 11'(ALT_INIMIGO - 1);
        acerta_celula = vivos_q[idx_q] &&
                        (bx_lo <= cx_hi) && (bx_hi >= cx_lo) &&
                        (by_lo <= cy_hi) && (by_hi >= cy_lo);
    end

    assign ultima = (idx_q == IW'(N - 1));
    assign soma   = {1'b0, pontos_q} + 17'(PONTOS_POR_ACERTO);

    // Next-state logic: restart first, then the FSM unless paused
    always_comb begin
        st_d         = st_q;
        idx_d        = idx_q;
        col_d        = col_q;
        lin_d        = lin_q;
        sx_d         = sx_q;
        sy_d         = sy_q;
        sr_d         = sr_q;
        gx_d         = gx_q;
        gy_d         = gy_q;
        last_x_d     = last_x_q;
        last_y_d     = last_y_q;
        prev_ativa_d = bus.bolaAtiva;
        vivos_d      = vivos_q;
        pontos_d     = pontos_q;
        indice_d     = indice_q;
        todos_d      = (vivos_q == '0);
        if (bus.reiniciarJogo) begin
            st_d     = OCIOSO;
            vivos_d  = '1;
            pontos_d = '0;
            todos_d  = 1'b0;
        end else if (!bus.pausa) begin
            case (st_q)
                OCIOSO: begin
                    if (disparo) st_d = AMOSTRA;
                end
                AMOSTRA: begin
                    sx_d     = bus.bolaX;
                    sy_d     = bus.bolaY;
                    sr_d     = bus.raio;
                    gx_d     = bus.gradeX;
                    gy_d     = bus.gradeY;
                    last_x_d = bus.bolaX;
                    last_y_d = bus.bolaY;
                    idx_d    = '0;
                    col_d    = '0;
                    lin_d    = '0;
                    st_d     = VARRE;
                end
                VARRE: begin
                    if (acerta_celula) begin
                        indice_d = 6'(idx_q);
                        st_d     = ACERTO;
                    end else if (ultima) begin
                        st_d = OCIOSO;
                    end else begin
                        idx_d = idx_q + IW'(1);
                        if (col_q == CW'(COLUNAS - 1)) begin
                            col_d = '0;
                            lin_d = lin_q + LW'(1);
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end
                end
                default: begin
                    vivos_d[idx_q] = 1'b0;
                    pontos_d       = soma[16] ? 16'hFFFF : soma[15:0];
                    st_d           = OCIOSO;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            st_q         <= OCIOSO;
            idx_q        <= '0;
            col_q        <= '0;
            lin_q        <= '0;
            sx_q         <= '0;
            sy_q         <= '0;
            sr_q         <= '0;
            gx_q         <= '0;
            gy_q         <= '0;
            last_x_q     <= 10'h3FF;
            last_y_q     <= 10'h3FF;
            prev_ativa_q <= 1'b0;
            vivos_q      <= '1;
            pontos_q     <= '0;
            indice_q     <= '0;
            todos_q      <= 1'b0;
        end else begin
            st_q         <= st_d;
            idx_q        <= idx_d;
            col_q        <= col_d;
            lin_q        <= lin_d;
            sx_q         <= sx_d;
            sy_q         <= sy_d;
            sr_q         <= sr_d;
            gx_q         <= gx_d;
            gy_q         <= gy_d;
            last_x_q     <= last_x_d;
            last_y_q     <= last_y_d;
            prev_ativa_q <= prev_ativa_d;
            vivos_q      <= vivos_d;
            pontos_q     <= pontos_d;
            indice_q     <= indice_d;
            todos_q      <= todos_d;
        end
    end

    // The hit pulse is the ACERTO cycle itself, suppressed while paused or restarting
    assign bus.acerto       = (st_q == ACERTO) && !bus.pausa && !bus.reiniciarJogo;
    assign bus.vivos        = vivos_q;
    assign bus.pontos       = pontos_q;
    assign bus.indiceAcerto = indice_q;
    assign bus.todosMortos  = todos_q;
    assign bus.ocupado      = (st_q != OCIOSO);
    assign estado_o         = st_q;
endmodule

// File: tb/tb_colisao_inimigos.sv
// Bench for colisao_inimigos: directed bullet shots against the default grid
// at (100, 50). Expected hits (cycle and index) go into a queue that a
// separate monitor drains whenever acerto is seen.
module tb_colisao_inimigos;
    logic        clk;
    logic        rst_n;
    logic [1:0]  estado;
    int          cyc;
    int          errors;
    int          checks;
    logic [21:0] exp_q[$];
    logic [31:0] exp_vivos;
    logic [15:0] exp_pontos;

    colisao_inimigos_if #(.NUM(32)) bus ();

    colisao_inimigos dut (
        .CLOCK_50 (clk),
        .reset    (rst_n),
        .bus      (bus),
        .estado_o (estado)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every acerto pulse must match the head of the expected queue
    always @(negedge clk) begin
        if (rst_n && bus.acerto === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_hit: got index %0d at cycle %0d expected none",
                         bus.indiceAcerto, cyc);
            end else begin
                logic [21:0] e;
                e = exp_q.pop_front();
                check("hit_cycle", 64'(16'(cyc)), 64'(e[21:6]));
                check("hit_index", 64'(bus.indiceAcerto), 64'(e[5:0]));
            end
        end
    end

    // One shot: launch bullet, optionally pause mid-scan, wait for idle, check model
    task automatic shoot(input int x, input int y, input int r, input bit hit, input int k,
                         input int p_at, input int p_len, input string nm);
        int       c0;
        int       fall;
        int       exp_fall;
        bit       done;
        logic [1:0] st_hold;
        @(posedge clk); #1;
        c0 = cyc;
        st_hold = 2'd0;
        if (hit) begin
            exp_q.push_back({16'(c0 + 3 + k + p_len), 6'(k)});
            exp_vivos[k] = 1'b0;
            exp_pontos   = exp_pontos + 16'd10;
        end
        bus.bolaX     = 10'(x);
        bus.bolaY     = 10'(y);
        bus.raio      = 10'(r);
        bus.bolaAtiva = 1'b1;
        done = 1'b0;
        fall = 0;
        for (int n = 1; n <= 200 && !done; n++) begin
            @(posedge clk); #1;
            if (p_len > 0 && n == p_at) begin
                bus.pausa = 1'b1;
                st_hold   = estado;
            end else if (p_len > 0 && n == p_at + p_len) begin
                bus.pausa = 1'b0;
            end else if (bus.pausa) begin
                check({"pause_state_", nm}, 64'(estado), 64'(st_hold));
            end
            @(negedge clk);
            if (!bus.ocupado) begin
                done = 1'b1;
                fall = cyc;
            end
        end
        exp_fall = hit ? (c0 + 4 + k + p_len) : (c0 + 2 + 32 + p_len);
        if (!done) $display("FAIL timeout_%s: got busy after 200 cycles expected idle", nm);
        check({"idle_cycle_", nm}, 64'(fall), 64'(exp_fall));
        bus.bolaAtiva = 1'b0;
        bus.pausa     = 1'b0;
        @(posedge clk); #1;
        check({"vivos_", nm}, 64'(bus.vivos), 64'(exp_vivos));
        check({"pontos_", nm}, 64'(bus.pontos), 64'(exp_pontos));
        check({"todos_", nm}, 64'(bus.todosMortos), 64'(exp_vivos == 32'd0));
    endtask

    task automatic restart();
        @(posedge clk); #1;
        bus.reiniciarJogo = 1'b1;
        @(posedge clk); #1;
        bus.reiniciarJogo = 1'b0;
        exp_vivos  = 32'hFFFF_FFFF;
        exp_pontos = 16'd0;
        @(negedge clk);
        check("restart_vivos", 64'(bus.vivos), 64'h0000_0000_FFFF_FFFF);
        check("restart_pontos", 64'(bus.pontos), 64'd0);
        check("restart_todos", 64'(bus.todosMortos), 64'd0);
        check("restart_ocupado", 64'(bus.ocupado), 64'd0);
    endtask

    // Directed scenarios
    initial begin
        cyc = 0; errors = 0; checks = 0;
        exp_vivos  = 32'hFFFF_FFFF;
        exp_pontos = 16'd0;
        rst_n = 1'b0;
        bus.reiniciarJogo = 1'b0;
        bus.pausa = 1'b0;
        bus.bolaAtiva = 1'b0;
        bus.bolaX = 10'd0; bus.bolaY = 10'd0; bus.raio = 10'd0;
        bus.gradeX = 10'd100; bus.gradeY = 10'd50;
        repeat (3) @(posedge clk);
        #1;
        check("rst_vivos", 64'(bus.vivos), 64'h0000_0000_FFFF_FFFF);
        check("rst_pontos", 64'(bus.pontos), 64'd0);
        check("rst_acerto", 64'(bus.acerto), 64'd0);
        check("rst_indice", 64'(bus.indiceAcerto), 64'd0);
        check("rst_todos", 64'(bus.todosMortos), 64'd0);
        check("rst_ocupado", 64'(bus.ocupado), 64'd0);
        rst_n = 1'b1;

        shoot(110, 60, 5, 1'b1, 0, 0, 0, "first_hit");
        shoot(130, 60, 5, 1'b0, 0, 0, 0, "gap_miss");
        restart();
        shoot(129, 60, 5, 1'b0, 0, 0, 0, "edge_miss");
        shoot(128, 60, 5, 1'b1, 0, 0, 0, "edge_touch");
        shoot(390, 150, 5, 1'b1, 31, 0, 0, "last_cell");
        shoot(390, 150, 5, 1'b0, 0, 0, 0, "dead_cell");

        restart();
        shoot(132, 72, 20, 1'b1, 0, 0, 0, "lowest_wins");
        shoot(132, 72, 20, 1'b1, 1, 0, 0, "next_lowest");
        for (int i = 2; i < 32; i++)
            shoot(112 + (i % 8) * 40, 58 + (i / 8) * 30, 1, 1'b1, i, 0, 0, "kill_all");
        check("score_320", 64'(bus.pontos), 64'd320);
        shoot(110, 60, 5, 1'b0, 0, 0, 0, "all_dead");
        restart();

        shoot(390, 150, 5, 1'b1, 31, 10, 10, "paused");

        // Asynchronous reset in the middle of a scan
        @(posedge clk); #1;
        bus.bolaX = 10'd130; bus.bolaY = 10'd60; bus.raio = 10'd5;
        bus.bolaAtiva = 1'b1;
        repeat (6) @(posedge clk);
        #3;
        check("mid_busy", 64'(bus.ocupado), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_vivos", 64'(bus.vivos), 64'h0000_0000_FFFF_FFFF);
        check("mid_rst_pontos", 64'(bus.pontos), 64'd0);
        check("mid_rst_acerto", 64'(bus.acerto), 64'd0);
        check("mid_rst_indice", 64'(bus.indiceAcerto), 64'd0);
        check("mid_rst_todos", 64'(bus.todosMortos), 64'd0);
        check("mid_rst_ocupado", 64'(bus.ocupado), 64'd0);
        @(posedge clk); #1;
        bus.bolaAtiva = 1'b0;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("pending_hits", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
